// File: rtl/mtm_alu_pkg.sv
// Constants shared by the serial front end and the serializer of the 32-bit ALU.
// Control-byte codes, opcode encodings and frame type bit values.
package mtm_alu_pkg;

  localparam logic [7:0] IDLE_CTL      = 8'hFF;
  localparam logic [7:0] ERR_DATA_CODE = 8'b11001001;
  localparam logic [7:0] ERR_CRC_CODE  = 8'b10100101;
  localparam logic [7:0] ERR_OP_CODE   = 8'b10010011;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_e;

  localparam logic FRAME_DATA = 1'b0;
  localparam logic FRAME_CMD  = 1'b1;

endpackage

// File: rtl/mtm_alu_crc4.sv
// Combinational CRC4 (x^4+x+1, init 0) over a 68-bit vector, MSB first.
// Shared with the serializer so both ends agree on the check value.
module mtm_alu_crc4
  import mtm_alu_pkg::*;
(
  input  logic [67:0] i_data,
  output logic [3:0]  o_crc
);

  logic [3:0] w_crc;
  logic       w_fb;

  always_comb begin
    w_crc = 4'd0;
    w_fb  = 1'b0;
    for (int i = 67; i >= 0; i--) begin
      w_fb  = w_crc[3] ^ i_data[i];
      w_crc = {w_crc[2:0], 1'b0} ^ {2'b00, w_fb, w_fb};
    end
    o_crc = w_crc;
  end

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Serial request front end: frames on sin are collected into {B,A} plus a command
// byte, checked for frame count and CRC4, and handed to the core as a 1-cycle request.
module mtm_alu_deserializer #(
  parameter int         DATA_FRAMES   = 8,
  parameter logic [7:0] IDLE_CTL      = mtm_alu_pkg::IDLE_CTL,
  parameter logic [7:0] ERR_DATA_CODE = mtm_alu_pkg::ERR_DATA_CODE,
  parameter logic [7:0] ERR_CRC_CODE  = mtm_alu_pkg::ERR_CRC_CODE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [7:0]  ctl_out,
  output logic        req_valid
);
  import mtm_alu_pkg::*;

  localparam int CNT_W = $clog2(DATA_FRAMES + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_FRAMES);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_FRAMES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TYPE = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic [1:0]       r_state;
  logic             r_type;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_byte;
  logic [63:0]      r_pkt;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [7:0]       r_ctl;
  logic             r_valid;
  logic [3:0]       w_crc;

  // In STOP, r_byte holds the complete command byte, so the CRC is ready to compare.
  mtm_alu_crc4 u_crc4 (
    .i_data ({r_pkt, 1'b1, r_byte[6:4]}),
    .o_crc  (w_crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_type      <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_byte      <= 8'd0;
      r_pkt       <= 64'd0;
      r_frame_cnt <= '0;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_ctl       <= IDLE_CTL;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ctl   <= IDLE_CTL;
      case (r_state)
        S_IDLE: begin
          if (!sin) r_state <= S_TYPE;
        end
        S_TYPE: begin
          r_type    <= sin;
          r_bit_cnt <= 3'd0;
          r_state   <= S_DATA;
        end
        S_DATA: begin
          r_byte    <= {r_byte[6:0], sin};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_state <= S_STOP;
        end
        S_STOP: begin
          r_state <= S_IDLE;
          if (!sin) begin
            r_valid     <= 1'b1;
            r_ctl       <= ERR_DATA_CODE;
            r_frame_cnt <= '0;
          end else if (r_type == FRAME_DATA) begin
            r_pkt <= {r_pkt[55:0], r_byte};
            if (r_frame_cnt != CNT_SAT) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
          end else begin
            r_valid     <= 1'b1;
            r_frame_cnt <= '0;
            if (r_frame_cnt != CNT_FULL) begin
              r_ctl <= ERR_DATA_CODE;
            end else if (w_crc != r_byte[3:0]) begin
              r_ctl <= ERR_CRC_CODE;
            end else begin
              // Unsupported opcodes pass through; the core raises the op error itself.
              r_ctl <= {1'b0, r_byte[6:0]};
              r_a   <= r_pkt[31:0];
              r_b   <= r_pkt[63:32];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign ctl_out   = r_ctl;
  assign req_valid = r_valid;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Self-checking bench for mtm_alu_deserializer: table vectors, random packets
// against a polynomial-division CRC model, and hand-written reset/framing sequences.
module tb_mtm_alu_deserializer;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic [31:0] A;
  logic [31:0] B;
  logic [7:0]  ctl_out;
  logic        req_valid;

  int total;
  int bad;
  int n_pulse;
  int exp_pulse;
  logic [31:0] exp_a;
  logic [31:0] exp_b;

  mtm_alu_deserializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .A         (A),
    .B         (B),
    .ctl_out   (ctl_out),
    .req_valid (req_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (req_valid === 1'b1) n_pulse++;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  cmd;
    int          nframes;
    logic [7:0]  exp_ctl;
    logic        exp_upd;
  } vec_t;

  vec_t vecs [8];

  // CRC as the remainder of (msg * x^4) divided by x^4+x+1.
  function automatic logic [3:0] model_crc(input logic [67:0] msg);
    logic [71:0] r;
    r = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [7:0] good_cmd(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    return {1'b0, op, model_crc({b, a, 1'b1, op})};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic send_packet(input logic [31:0] a, input logic [31:0] b,
                             input logic [7:0] cmd, input int nframes);
    logic [63:0] pkt;
    logic [7:0]  byt;
    pkt = {b, a};
    for (int i = 0; i < nframes; i++) begin
      byt = (i < 8) ? pkt[63 - 8*i -: 8] : 8'h5A;
      send_frame(1'b0, byt, 1'b1);
    end
    send_frame(1'b1, cmd, 1'b1);
  endtask

  // Called right after the edge that sampled the last stop bit.
  task automatic check_emit(input string nm, input logic [7:0] ectl, input logic upd);
    if (upd) begin
      exp_a = exp_a;
    end
    exp_pulse++;
    chk({nm, ".valid"}, 64'(req_valid), 64'd1);
    chk({nm, ".ctl"}, 64'(ctl_out), 64'(ectl));
    chk({nm, ".A"}, 64'(A), 64'(exp_a));
    chk({nm, ".B"}, 64'(B), 64'(exp_b));
    send_bit(1'b1);
    chk({nm, ".valid_drop"}, 64'(req_valid), 64'd0);
    chk({nm, ".ctl_idle"}, 64'(ctl_out), 64'hFF);
    $display("%s: ctl=%02h A=%08h B=%08h", nm, ectl, exp_a, exp_b);
  endtask

  task automatic run_packet(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic [7:0] cmd, input int nframes,
                            input logic [7:0] ectl, input logic upd);
    send_packet(a, b, cmd, nframes);
    if (upd) begin
      exp_a = a;
      exp_b = b;
    end
    check_emit(nm, ectl, upd);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;
    logic [7:0]  rcmd;
    total = 0; bad = 0; n_pulse = 0; exp_pulse = 0;
    exp_a = 32'd0; exp_b = 32'd0;

    vecs[0] = '{"zero",   32'h0, 32'h0, 8'h0B, 8, 8'h0B, 1'b1};
    vecs[1] = '{"add",    32'hDEADBEEF, 32'h12345678,
                good_cmd(32'hDEADBEEF, 32'h12345678, 3'b100), 8, 8'h00, 1'b1};
    vecs[2] = '{"crc_err", 32'h0, 32'h0, 8'h0A, 8, 8'hA5, 1'b0};
    vecs[3] = '{"short",  32'h1, 32'h2, good_cmd(32'h1, 32'h2, 3'b000), 7, 8'hC9, 1'b0};
    vecs[4] = '{"long",   32'h1, 32'h2, good_cmd(32'h1, 32'h2, 3'b000), 9, 8'hC9, 1'b0};
    vecs[5] = '{"or",     32'h00FF00FF, 32'hA5A5A5A5,
                good_cmd(32'h00FF00FF, 32'hA5A5A5A5, 3'b001), 8, 8'h00, 1'b1};
    vecs[6] = '{"sub",    32'h80000000, 32'h7FFFFFFF,
                good_cmd(32'h80000000, 32'h7FFFFFFF, 3'b101), 8, 8'h00, 1'b1};
    vecs[7] = '{"bad_op", 32'hCAFEF00D, 32'h0BADBEEF,
                good_cmd(32'hCAFEF00D, 32'h0BADBEEF, 3'b111) | 8'h80, 8, 8'h00, 1'b1};
    for (int i = 0; i < 8; i++)
      if (vecs[i].exp_upd && i != 0) vecs[i].exp_ctl = {1'b0, vecs[i].cmd[6:0]};

    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.A", 64'(A), 64'd0);
    chk("reset.B", 64'(B), 64'd0);
    chk("reset.ctl", 64'(ctl_out), 64'hFF);
    chk("reset.valid", 64'(req_valid), 64'd0);
    rst_n = 1'b1;
    repeat (2) send_bit(1'b1);

    for (int i = 0; i < 8; i++)
      run_packet(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cmd, vecs[i].nframes,
                 vecs[i].exp_ctl, vecs[i].exp_upd);

    // Framing error on data frame 3, then a normal packet.
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    send_frame(1'b0, 8'h33, 1'b0);
    check_emit("framing", 8'hC9, 1'b0);
    run_packet("after_framing", 32'h01020304, 32'h05060708,
               good_cmd(32'h01020304, 32'h05060708, 3'b100), 8,
               good_cmd(32'h01020304, 32'h05060708, 3'b100), 1'b1);

    // sin stuck low is an all-zero frame with a bad stop bit.
    for (int i = 0; i < 11; i++) send_bit(1'b0);
    check_emit("sin_low", 8'hC9, 1'b0);

    // Reset during frame 5.
    send_frame(1'b0, 8'hAA, 1'b1);
    send_frame(1'b0, 8'hBB, 1'b1);
    send_frame(1'b0, 8'hCC, 1'b1);
    send_frame(1'b0, 8'hDD, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.A", 64'(A), 64'd0);
    chk("midrst.B", 64'(B), 64'd0);
    chk("midrst.ctl", 64'(ctl_out), 64'hFF);
    chk("midrst.valid", 64'(req_valid), 64'd0);
    exp_a = 32'd0;
    exp_b = 32'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst.pulses", 64'(n_pulse), 64'(exp_pulse));
    run_packet("after_reset", 32'h89ABCDEF, 32'h76543210,
               good_cmd(32'h89ABCDEF, 32'h76543210, 3'b101), 8,
               good_cmd(32'h89ABCDEF, 32'h76543210, 3'b101), 1'b1);

    for (int n = 0; n < 200; n++) begin
      ra   = $urandom;
      rb   = $urandom;
      rop  = 3'($urandom_range(0, 7));
      rcmd = good_cmd(ra, rb, rop);
      repeat ($urandom_range(0, 2)) send_bit(1'b1);
      run_packet($sformatf("rnd%0d", n), ra, rb, rcmd, 8, rcmd, 1'b1);
    end

    repeat (3) send_bit(1'b1);
    chk("pulse_count", 64'(n_pulse), 64'(exp_pulse));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mtm_alu_deserializer.md
Name: mtm_alu_deserializer

Overview:
Serial-input front end of the 32-bit ALU. It receives the bit-serial request packet on `sin`: 8 data frames carrying B then A, followed by 1 command frame. It checks frame count and CRC4, then presents A, B and an 8-bit control byte to the ALU core. The control byte is either `{0, OP[2:0], CRC[3:0]}` or an error code; the core decodes it directly.

Parameters:
DATA_FRAMES, 8, number of data frames expected before the command frame
IDLE_CTL, 8'hFF, ctl_out value when no request is pending
ERR_DATA_CODE, 8'b11001001, ctl_out for bad frame count or framing error
ERR_CRC_CODE, 8'b10100101, ctl_out for CRC mismatch

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sin  in  1  serial input, one bit per clk, idles high
A  out  32  operand A
B  out  32  operand B
ctl_out  out  8  control/error byte to the core
req_valid  out  1  single-cycle strobe; A, B, ctl_out carry a new request

Behaviour:
- Interface: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: A=0, B=0, ctl_out=IDLE_CTL, req_valid=0. All state clears: FSM to IDLE, frame counter 0, shift registers 0.
- Frame format, 11 bits, MSB first: start(0), type (0=data, 1=cmd), d[7:0], stop(1).
- Frame FSM:
  - IDLE: wait for sin=0.
  - TYPE: latch the type bit.
  - DATA: 8 cycles, shift d in MSB first; bit counter 0..7.
  - STOP: check the stop bit, then return to IDLE. A start bit on the cycle after STOP must be accepted (back-to-back frames).
- Data frame with good stop bit:
  - 64-bit packet shift register `{B,A}` shifts left by 8.
  - Frame counter increments, saturating at DATA_FRAMES+1.
  - Byte order: B[31:24] first, A[7:0] last.
- Command frame with good stop bit: cmd = `{x, OP[2:0], CRC[3:0]}`; bit 7 is ignored.
  - If frame counter != DATA_FRAMES: emit ERR_DATA_CODE.
  - Else compute CRC4 (polynomial x^4+x+1, init 0) over the 68-bit vector `{B, A, 1'b1, OP}`, MSB first.
    - Mismatch: emit ERR_CRC_CODE.
    - Match: emit `{1'b0, OP, CRC}`. An unsupported OP is passed through unchanged; the core flags it.
  - The frame counter clears in all three cases.
- Stop bit = 0 on any frame: emit ERR_DATA_CODE, abort the packet, clear the frame counter, go to IDLE.
- "Emit":
  - On the clock edge after the STOP cycle, register A, B and ctl_out and pulse req_valid for exactly 1 cycle.
  - On the following edge ctl_out returns to IDLE_CTL.
  - A and B hold their last values.
  - On an error emit, A and B are not updated.
- Latency: the request is visible 1 clk after the cmd stop bit is sampled.
- More than 8 data frames: the counter saturates; the next cmd yields ERR_DATA_CODE.
- Reset asserted mid-frame or mid-packet: immediate return to reset values; partial data discarded; no emit.
- sin=0 held in IDLE: interpreted as a start bit every 11 cycles. No glitch filter.

Decomposition:
- Shared package mtm_alu_pkg holds:
  - IDLE_CTL, ERR_DATA_CODE, ERR_CRC_CODE and the ERR_OP code 8'b10010011;
  - OP encodings AND=000, OR=001, ADD=100, SUB=101;
  - frame type constants DATA=0, CMD=1.
- One sub-module, mtm_alu_crc4: combinational CRC4 over 68 bits (x^4+x+1, init 0). The serializer downstream reuses it.

Test Plan:
- Nominal, zero operands: send B=0, A=0, cmd 8'h0B (OP=000, CRC=1011) -> one cycle after the cmd stop bit: A=0, B=0, ctl_out=8'h0B, req_valid=1 for 1 clk, then ctl_out=8'hFF.
- Nominal, random operands: 200 random A/B/OP with CRC from a bench model -> ctl_out={0,OP,CRC}; A and B match exactly; byte order B-first.
- CRC error: same as the first scenario but cmd 8'h0A -> ctl_out=8'b10100101 for 1 clk; A and B unchanged from the previous values.
- Frame count error, short: 7 data frames then cmd -> ctl_out=8'b11001001. Long: 9 data frames then cmd -> 8'b11001001.
- Framing error: stop bit=0 on data frame 3 -> ctl_out=8'b11001001. A following correct 9-frame packet is then accepted normally.
- Reset mid-packet: drop rst_n during frame 5 -> outputs return to reset values asynchronously; no req_valid. A full packet sent after release is accepted with back-to-back frames (no idle bits between frames).
